// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage EN/FLUSH and PC_EN from cache handshakes, load-use, MEM redirects and halt.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             redirect,
    input  logic             halt_in,
    input  logic             idex_load,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    output logic             PC_EN,
    output logic             IF_EN,
    output logic             IF_FLUSH,
    output logic             ID_EN,
    output logic             ID_FLUSH,
    output logic             EX_EN,
    output logic             EX_FLUSH,
    output logic             MEM_EN,
    output logic             MEM_FLUSH,
    output logic             halt,
    output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] lu_stalls
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, SQUASH = 2'd1, HALTED = 2'd2} state_t;

    state_t     st, nxt;
    logic       mstall, lu, pc;
    logic [3:0] en, fl;   // bit 0 = IF/ID ... bit 3 = MEM/WB

    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    assign mstall = mem_req & ~dhit;
    assign lu     = idex_load & (idex_rd != '0) & ((idex_rd == dec_rs) | (idex_rd == dec_rt));

    always_comb begin
        pc  = 1'b0;
        en  = 4'b0000;
        fl  = 4'b0000;
        nxt = st;
        case (st)
            RUN, SQUASH: begin
                if (halt_in & ~mstall) begin
                    en  = 4'b1111;
                    nxt = HALTED;
                end else if (mstall) begin
                    en  = 4'b0000;
                end else if (redirect) begin
                    pc  = 1'b1;
                    en  = 4'b1111;
                    fl  = 4'b0111;
                    nxt = ihit ? RUN : SQUASH;
                end else if (st == SQUASH) begin
                    // the word returning now belongs to the wrong path: drop it and refetch
                    en = 4'b1111;
                    fl = {2'b00, ihit & lu, 1'b1};
                    if (ihit) nxt = RUN;
                end else if (lu) begin
                    en = 4'b1110;
                    fl = 4'b0010;
                end else if (~ihit) begin
                    en = 4'b1111;
                    fl = 4'b0001;
                end else begin
                    pc = 1'b1;
                    en = 4'b1111;
                end
            end
            default: nxt = HALTED;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) st <= RUN;
        else     st <= nxt;
    end

    assign PC_EN     = ~RST & pc;
    assign IF_EN     = ~RST & en[0];
    assign IF_FLUSH  = ~RST & fl[0];
    assign ID_EN     = ~RST & en[1];
    assign ID_FLUSH  = ~RST & fl[1];
    assign EX_EN     = ~RST & en[2];
    assign EX_FLUSH  = ~RST & fl[2];
    assign MEM_EN    = ~RST & en[3];
    assign MEM_FLUSH = ~RST & fl[3];
    assign halt      = ~RST & (st == HALTED);
    assign state     = RST ? 2'd0 : st;

`ifdef HAZARD_PERF_CNT_EN
    logic running, redir_acc, lu_act;

    assign running   = (st != HALTED);
    assign redir_acc = running & ~mstall & ~halt_in & redirect;
    assign lu_act    = (st == RUN) & ~mstall & ~halt_in & ~redirect & lu;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_events <= '0;
            lu_stalls    <= '0;
        end else begin
            if (running & ~pc & (stall_cycles != '1))
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            if (redir_acc & (flush_events != '1))
                flush_events <= flush_events + {{(CNT_W-1){1'b0}}, 1'b1};
            if (lu_act & (lu_stalls != '1))
                lu_stalls <= lu_stalls + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table with expected-output scoreboard, random invariant sweep,
// and a counter sequence when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ihit = 1'b0, dhit = 1'b0, mem_req = 1'b0, redirect = 1'b0, halt_in = 1'b0, idex_load = 1'b0;
    logic [4:0] idex_rd = '0, dec_rs = '0, dec_rt = '0;
    logic       PC_EN, IF_EN, IF_FLUSH, ID_EN, ID_FLUSH, EX_EN, EX_FLUSH, MEM_EN, MEM_FLUSH, halt;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, lu_stalls;
`endif

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .redirect(redirect), .halt_in(halt_in), .idex_load(idex_load),
        .idex_rd(idex_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .PC_EN(PC_EN), .IF_EN(IF_EN), .IF_FLUSH(IF_FLUSH), .ID_EN(ID_EN), .ID_FLUSH(ID_FLUSH),
        .EX_EN(EX_EN), .EX_FLUSH(EX_FLUSH), .MEM_EN(MEM_EN), .MEM_FLUSH(MEM_FLUSH),
        .halt(halt), .state(state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events), .lu_stalls(lu_stalls)
`endif
    );

    always #5 CLK = ~CLK;

    localparam int F = 0, A = 1, B = 2;

    typedef struct {
        string      name;
        logic       rst, ihit, dhit, mem_req, redirect, halt_in, load;
        logic [4:0] rd, rs, rt;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] exp_q[$];
    string       name_q[$];

    function automatic logic [1:0] md(input int m);
        return (m == A) ? 2'b10 : (m == B) ? 2'b11 : 2'b00;
    endfunction

    // {PC_EN, IF_EN, IF_FLUSH, ID_EN, ID_FLUSH, EX_EN, EX_FLUSH, MEM_EN, MEM_FLUSH, halt, state}
    function automatic logic [11:0] e(input bit pc, input int mi, input int mid, input int mx,
                                      input int mm, input bit h, input logic [1:0] st);
        return {pc, md(mi), md(mid), md(mx), md(mm), h, st};
    endfunction

    function automatic vec_t mkv(input string n, input logic r, input logic ih, input logic dh,
                                 input logic mr, input logic rdr, input logic hl, input logic ld,
                                 input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [11:0] x);
        vec_t v;
        v.name = n; v.rst = r; v.ihit = ih; v.dhit = dh; v.mem_req = mr; v.redirect = rdr;
        v.halt_in = hl; v.load = ld; v.rd = rd; v.rs = rs; v.rt = rt; v.exp = x;
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {PC_EN, IF_EN, IF_FLUSH, ID_EN, ID_FLUSH, EX_EN, EX_FLUSH, MEM_EN, MEM_FLUSH, halt, state};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
    endtask

    // drive one cycle, score the outputs mid-cycle, then step past the clock edge
    task automatic apply(input vec_t v);
        RST = v.rst; ihit = v.ihit; dhit = v.dhit; mem_req = v.mem_req; redirect = v.redirect;
        halt_in = v.halt_in; idex_load = v.load; idex_rd = v.rd; dec_rs = v.rs; dec_rt = v.rt;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge CLK);
        chk(name_q.pop_front(), {20'd0, outs()}, {20'd0, exp_q.pop_front()});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [11:0] z, adv;
        z   = e(0, F, F, F, F, 0, 2'd0);
        adv = e(1, A, A, A, A, 0, 2'd0);
        //                 name          rst ih dh mr rd hl ld  rd     rs     rt     expected
        tbl.push_back(mkv("rst0",        1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, z));
        tbl.push_back(mkv("rst1",        1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, z));
        tbl.push_back(mkv("adv0",        0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, adv));
        tbl.push_back(mkv("lu_rt",       0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8, e(0, F, B, A, A, 0, 0)));
        tbl.push_back(mkv("lu_rs",       0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, e(0, F, B, A, A, 0, 0)));
        tbl.push_back(mkv("lu_r0",       0, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, adv));
        tbl.push_back(mkv("lu_nomatch",  0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd4, adv));
        tbl.push_back(mkv("lu_noihit",   0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd1, e(0, F, B, A, A, 0, 0)));
        tbl.push_back(mkv("mstall1",     0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, z));
        tbl.push_back(mkv("mstall2",     0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, z));
        tbl.push_back(mkv("mstall3",     0, 1, 0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd8, z));
        tbl.push_back(mkv("dhit_redir",  0, 1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, e(1, B, B, B, A, 0, 0)));
        tbl.push_back(mkv("imiss",       0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, e(0, B, A, A, A, 0, 0)));
        tbl.push_back(mkv("dhit_adv",    0, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, adv));
        tbl.push_back(mkv("redir_miss",  0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, e(1, B, B, B, A, 0, 0)));
        tbl.push_back(mkv("sq_ihit",     0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, e(0, B, A, A, A, 0, 1)));
        tbl.push_back(mkv("sq_back_run", 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, adv));
        tbl.push_back(mkv("redir_miss2", 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, e(1, B, B, B, A, 0, 0)));
        tbl.push_back(mkv("sq_imiss",    0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, e(0, B, A, A, A, 0, 1)));
        tbl.push_back(mkv("sq_mstall",   0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, e(0, F, F, F, F, 0, 1)));
        tbl.push_back(mkv("sq_redir_m",  0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, e(1, B, B, B, A, 0, 1)));
        tbl.push_back(mkv("sq_redir_h",  0, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, e(1, B, B, B, A, 0, 1)));
        tbl.push_back(mkv("adv1",        0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, adv));
        tbl.push_back(mkv("halt_mstall", 0, 1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, z));
        tbl.push_back(mkv("halt_go",     0, 1, 1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, e(0, A, A, A, A, 0, 0)));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mkv($sformatf("halted%0d", i), 0, 1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0,
                              e(0, F, F, F, F, 1, 2)));
        tbl.push_back(mkv("halt_rst",    1, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, z));
        tbl.push_back(mkv("adv_after",   0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, adv));

        @(posedge CLK);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // random sweep: each stage may only flush while enabled, halt tracks HALTED
        for (int i = 0; i < 300; i++) begin
            RST = ($urandom_range(0, 40) == 0);
            ihit = $urandom_range(0, 1); dhit = $urandom_range(0, 1); mem_req = $urandom_range(0, 1);
            redirect = ($urandom_range(0, 3) == 0); halt_in = ($urandom_range(0, 30) == 0);
            idex_load = $urandom_range(0, 1); idex_rd = 5'($urandom_range(0, 3));
            dec_rs = 5'($urandom_range(0, 3)); dec_rt = 5'($urandom_range(0, 3));
            @(negedge CLK);
            chk("flush_needs_en",
                {31'd0, (~IF_FLUSH | IF_EN) & (~ID_FLUSH | ID_EN) & (~EX_FLUSH | EX_EN) & (~MEM_FLUSH | MEM_EN)},
                32'd1);
            chk("halt_vs_state", {31'd0, halt}, {31'd0, state == 2'd2});
            @(posedge CLK);
            #1;
        end

`ifdef HAZARD_PERF_CNT_EN
        apply(mkv("pc_rst",   1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, z));
        apply(mkv("pc_lu",    0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd0, 5'd8, e(0, F, B, A, A, 0, 0)));
        apply(mkv("pc_imiss", 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, e(0, B, A, A, A, 0, 0)));
        apply(mkv("pc_redir", 0, 1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, e(1, B, B, B, A, 0, 0)));
        chk("lu_stalls",    lu_stalls,    32'd1);
        chk("flush_events", flush_events, 32'd1);
        chk("stall_cycles", stall_cycles, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Computes the per-stage enable and flush strobes, and the PC enable, from four sources: cache handshakes, the load-use hazard, branch/jump redirects resolved in MEM, and halt.
- Holds the sequential hazard state: a wrong-path fetch squash and a sticky halt.
- Sits beside the datapath top and drives the register bank's EN/FLUSH inputs directly.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 32, performance counter width (used only with PERF_CNT_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
mem_req  in  1  EX/MEM holds a load or store (EX_dREN|EX_dWEN)
redirect  in  1  taken branch or jump resolved from EX/MEM; PC loads target when PC_EN
halt_in  in  1  EX/MEM halt flag (EX_halt)
idex_load  in  1  ID/EX holds a load (ID_dREN)
idex_rd  in  REG_W  destination register of the ID/EX instruction
dec_rs  in  REG_W  rs of the IF/ID instruction
dec_rt  in  REG_W  rt of the IF/ID instruction
PC_EN  out  1  PC update enable
IF_EN, IF_FLUSH  out  1 each  IF/ID enable / zero
ID_EN, ID_FLUSH  out  1 each  ID/EX enable / zero
EX_EN, EX_FLUSH  out  1 each  EX/MEM enable / zero
MEM_EN, MEM_FLUSH  out  1 each  MEM/WB enable / zero
halt  out  1  sticky processor-halted flag
state  out  2  current state: RUN=0, SQUASH=1, HALTED=2

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous, active-high.
- RST samples high:
  - Next state is RUN; halt=0; counters clear.
  - While RST is high, all outputs are forced to 0.
- Outputs are combinational from the registered state and the current inputs. The only registered elements are the state and the counters.
- "Advance" means EN=1, FLUSH=0. "Bubble" means EN=1, FLUSH=1. "Freeze" means EN=0.
- Conditions:
  - mstall = mem_req & ~dhit
  - lu = idex_load & (idex_rd != 0) & (idex_rd == dec_rs | idex_rd == dec_rt)
- RUN priority, highest first:
  1. halt_in & ~mstall: all stages advance, PC_EN=0; next state HALTED.
  2. mstall: freeze all four stages, PC_EN=0. Overrides redirect, lu and ihit.
  3. redirect: PC_EN=1; bubble IF, ID and EX; MEM advances. If ~ihit, next state SQUASH (the fetch in flight is wrong-path).
  4. lu: PC_EN=0; IF freeze; ID bubble; EX and MEM advance.
  5. ~ihit: PC_EN=0; IF bubble; ID, EX and MEM advance.
  6. Otherwise: everything advances, PC_EN=1.
- SQUASH:
  - Same priority list, except the returning wrong-path word is discarded.
  - On ihit (no mstall or redirect): IF bubble, PC_EN=0 so the target is refetched; ID, EX and MEM per lu rules; next state RUN.
  - On ~ihit: treat as rule 5 and stay in SQUASH.
  - Redirect in SQUASH: apply rule 3; stay in SQUASH if ~ihit, else go to RUN.
  - mstall in SQUASH: freeze all and stay in SQUASH.
- HALTED:
  - PC_EN=0; every EN=0 and every FLUSH=0; halt=1.
  - Exit only on RST.
- halt output is 1 in HALTED, else 0.
- Register 0 never causes a load-use stall.
- No two FLUSH strobes conflict: each stage's FLUSH asserts only together with its EN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three output ports are added, each CNT_W bits wide, saturating, cleared on RST, and frozen in HALTED:
  - stall_cycles: count of cycles with PC_EN=0 outside HALTED
  - flush_events: count of cycles with redirect accepted
  - lu_stalls: count of cycles with rule 4 active
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold RST high for 2 cycles with ihit=1 -> all outputs 0, state=0. On the first cycle after release with ihit=1 and no hazards -> PC_EN and every EN=1, every FLUSH=0.
- Load-use: idex_load=1, idex_rd=8, dec_rt=8, ihit=1 -> PC_EN=0, IF_EN=0, ID_EN=1, ID_FLUSH=1, EX_EN=MEM_EN=1. Repeat with idex_rd=0 -> no stall.
- Data wait: mem_req=1, dhit=0 for 3 cycles, with redirect=1 during them -> all EN=0, PC_EN=0 throughout. Cycle 4 with dhit=1 -> redirect is honoured: IF/ID/EX bubble, PC_EN=1.
- Wrong-path squash: redirect=1 with ihit=0 -> PC_EN=1, IF/ID/EX bubble, state goes to 1. Next cycle ihit=1 -> IF bubble, PC_EN=0, state goes to 0. Following cycle ihit=1 -> normal advance.
- Halt: halt_in=1 with no mstall -> all advance, next cycle state=2, halt=1, all EN=0. Apply redirect and ihit for 5 cycles -> no change. RST -> state=0.
- With HAZARD_PERF_CNT_EN, run the sequence lu, ~ihit, redirect -> lu_stalls=1, flush_events=1, stall_cycles=2.
